// File: rtl/bm_dl_multicycle_chunk_adder.sv
// Multicycle chunked add/sub: WIDTH-bit operands processed CHUNK bits per cycle.
// Latency NCHUNK cycles from acceptance to out_valid; DONE holds while out_ready is low.
// Optional signed-overflow output guarded by CHUNK_ADDER_OVERFLOW_EN.
module bm_dl_multicycle_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef CHUNK_ADDER_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q;
  logic [WIDTH-1:0] a_sh_d, b_sh_d, sum_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_c;
`ifdef CHUNK_ADDER_OVERFLOW_EN
  logic             ovf_q;
  logic             carry_msb;
`endif

  // Ripple chain over the low CHUNK bits of the operand shift registers.
  always_comb begin : chain
    logic cy;
    cy      = carry_q;
    chunk_s = '0;
`ifdef CHUNK_ADDER_OVERFLOW_EN
    carry_msb = 1'b0;
`endif
    for (int i = 0; i < CHUNK; i++) begin
`ifdef CHUNK_ADDER_OVERFLOW_EN
      if (i == CHUNK - 1) carry_msb = cy;
`endif
      chunk_s[i] = a_sh_q[i] ^ b_sh_q[i] ^ cy;
      cy = (a_sh_q[i] & b_sh_q[i]) | (cy & (a_sh_q[i] ^ b_sh_q[i]));
    end
    chunk_c = cy;
  end

  always_comb begin
    a_sh_d = a_sh_q >> CHUNK;
    b_sh_d = b_sh_q >> CHUNK;
    sum_d  = (sum_q >> CHUNK) | (WIDTH'(chunk_s) << (WIDTH - CHUNK));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef CHUNK_ADDER_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q     <= a;
            b_sh_q     <= sub ? ~b : b;
            carry_q    <= sub ? 1'b1 : cin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_d;
          b_sh_q  <= b_sh_d;
          sum_q   <= sum_d;
          carry_q <= chunk_c;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cout_q      <= chunk_c;
`ifdef CHUNK_ADDER_OVERFLOW_EN
            ovf_q       <= chunk_c ^ carry_msb;
`endif
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef CHUNK_ADDER_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_bm_dl_multicycle_chunk_adder.sv
// Directed bench for the chunked adder: 16/4 main instance plus an 8/8 single-chunk instance.
module tb_bm_dl_multicycle_chunk_adder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0, sum;
  logic        out_valid, out_ready = 1'b1, cout;
`ifdef CHUNK_ADDER_OVERFLOW_EN
  logic        ovf, v_ovf;
`endif

  logic       v_in_valid = 1'b0, v_in_ready, v_cin = 1'b0, v_sub = 1'b0;
  logic [7:0] v_a = '0, v_b = '0, v_sum;
  logic       v_out_valid, v_cout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  bm_dl_multicycle_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef CHUNK_ADDER_OVERFLOW_EN
    .ovf(ovf),
`endif
    .sum(sum), .cout(cout)
  );

  bm_dl_multicycle_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut_one (
    .clock(clock), .reset_n(reset_n),
    .in_valid(v_in_valid), .in_ready(v_in_ready),
    .a(v_a), .b(v_b), .cin(v_cin), .sub(v_sub),
    .out_valid(v_out_valid), .out_ready(1'b1),
`ifdef CHUNK_ADDER_OVERFLOW_EN
    .ovf(v_ovf),
`endif
    .sum(v_sum), .cout(v_cout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Launch one operation from IDLE with out_ready high and check result and timing.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tc, input logic ts,
                        input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
`ifdef CHUNK_ADDER_OVERFLOW_EN
    check({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) check({tag, "_eo"}, eo, 0);
`endif
    @(posedge clock); #1;
    check({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  task automatic run_one(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic tc, input logic ts, input logic [7:0] es, input logic ec);
    int lat;
    v_a = ta; v_b = tb_; v_cin = tc; v_sub = ts; v_in_valid = 1'b1;
    @(posedge clock); #1;
    v_in_valid = 1'b0;
    lat = 0;
    while (!v_out_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 1);
    check({tag, "_sum"}, v_sum, es);
    check({tag, "_cout"}, v_cout, ec);
    @(posedge clock); #1;
  endtask

  initial begin
    int moved;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    run_op("add_basic", 16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0);
    run_op("carry_all", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
    run_op("carry_cin", 16'hFFFF, 16'h0001, 1, 0, 16'h0001, 1, 0);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0);
    run_op("sub_noborrow", 16'h0007, 16'h0005, 0, 1, 16'h0002, 1, 0);
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
    run_op("ovf_neg", 16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1);
    run_op("ovf_none", 16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);

    // Backpressure: hold DONE for 10 cycles while offering new operands.
    out_ready = 1'b0;
    a = 16'h00FF; b = 16'h0F01; cin = 0; sub = 0; in_valid = 1'b1;
    @(posedge clock); #1;
    a = 16'hAAAA; b = 16'h5555;
    begin
      int lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge clock); #1;
        lat++;
      end
      check("bp_lat", lat, 4);
    end
    moved = 0;
    for (int i = 0; i < 10; i++) begin
      a = a + 16'h0101;
      @(posedge clock); #1;
      if (!out_valid || in_ready || sum !== 16'h1000 || cout !== 1'b0) moved++;
    end
    check("bp_stable", moved, 0);
    check("bp_sum", sum, 16'h1000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("bp_release", {out_valid, in_ready}, 2'b01);
    @(posedge clock); #1;
    check("bp_not_taken", {out_valid, in_ready}, 2'b01);

    // Reset in the middle of RUN.
    a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_cout", cout, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    run_op("post_rst", 16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0);

    // Single-chunk instance: one RUN cycle.
    run_one("one_carry", 8'hFF, 8'h01, 0, 0, 8'h00, 1);
    run_one("one_sub", 8'h10, 8'h20, 1, 1, 8'hF0, 0);
    run_one("one_cin", 8'h3C, 8'h41, 1, 0, 8'h7E, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
